// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX encapsulation sequencer.
// The FCS_EN macro controls whether the FCS stage encoding can appear on stage_oh.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PAY,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

    localparam logic [3:0] STAGE_IDLE = 4'b0000;
    localparam logic [3:0] STAGE_PRE  = 4'b0001;
    localparam logic [3:0] STAGE_PAY  = 4'b0010;
    localparam logic [3:0] STAGE_PAD  = 4'b0100;
    localparam logic [3:0] STAGE_FCS  = 4'b1000;

    function automatic logic [3:0] stage_of(input state_t s);
        logic [3:0] oh;
        oh = STAGE_IDLE;
        case (s)
            PRE, SFD: oh = STAGE_PRE;
            PAY:      oh = STAGE_PAY;
            PAD:      oh = STAGE_PAD;
`ifdef FCS_EN
            FCS:      oh = STAGE_FCS;
`endif
            default:  oh = STAGE_IDLE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected, LSB-first) update by one data byte.
// Only instantiated when FCS_EN is defined.
module eth_crc32_byte
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REF = {<<{CRC_POLY}};

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ POLY_REF;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_stage_seq.sv
// Ethernet TX encapsulation sequencer: preamble, SFD, payload pass-through, pad,
// optional FCS (macro FCS_EN) and inter-frame gap.
module eth_tx_stage_seq
    import eth_tx_pkg::*;
#(
    parameter int PRE_LEN = 7,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12,
    parameter int CNT_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [3:0] stage_oh,
    output logic       busy,
    output logic       err_oversize
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         stage_oh_q, stage_oh_d;

    logic [7:0]         m_data_c;
    logic               m_valid_c, m_last_c, s_ready_c, err_c;

`ifdef FCS_EN
    logic [31:0]        crc_q, crc_d, crc_next;
    logic [7:0]         crc_byte;
    logic               crc_en;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        m_data_c  = '0;
        m_valid_c = 1'b0;
        m_last_c  = 1'b0;
        s_ready_c = 1'b0;
        err_c     = 1'b0;
`ifdef FCS_EN
        crc_en    = 1'b0;
        crc_byte  = '0;
        crc_d     = crc_q;
`endif
        unique case (state_q)
            IDLE: begin
                ovf_d = 1'b0;
`ifdef FCS_EN
                crc_d = CRC_INIT;
`endif
                if (s_valid) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                m_data_c  = PREAMBLE_BYTE;
                m_valid_c = 1'b1;
                if (m_ready) begin
                    if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                        state_d = SFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SFD: begin
                m_data_c  = SFD_BYTE;
                m_valid_c = 1'b1;
                if (m_ready) begin
                    state_d = PAY;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            PAY: begin
                // Past MAX_LEN the client is drained without forwarding or counting.
                if (cnt_q == CNT_W'(MAX_LEN)) begin
                    s_ready_c = 1'b1;
                    err_c     = s_valid & ~ovf_q;
                    if (s_valid) ovf_d = 1'b1;
                end else begin
                    m_data_c  = s_data;
                    m_valid_c = s_valid;
                    s_ready_c = m_ready;
`ifndef FCS_EN
                    m_last_c  = s_last && (cnt_q >= CNT_W'(MIN_LEN - 1));
`endif
                end
                if (s_valid && s_ready_c) begin
                    if (cnt_q != CNT_W'(MAX_LEN)) begin
                        cnt_d = cnt_q + 1'b1;
`ifdef FCS_EN
                        crc_en   = 1'b1;
                        crc_byte = s_data;
`endif
                    end
                    if (s_last && (cnt_q < CNT_W'(MIN_LEN - 1))) begin
                        state_d = PAD;
                    end else if (s_last) begin
`ifdef FCS_EN
                        state_d = FCS;
`else
                        state_d = IFG;
`endif
                        cnt_d = '0;
                    end
                end
            end
            PAD: begin
                m_valid_c = 1'b1;
`ifndef FCS_EN
                m_last_c  = (cnt_q == CNT_W'(MIN_LEN - 1));
`endif
                if (m_ready) begin
`ifdef FCS_EN
                    crc_en = 1'b1;
`endif
                    if (cnt_q == CNT_W'(MIN_LEN - 1)) begin
`ifdef FCS_EN
                        state_d = FCS;
`else
                        state_d = IFG;
`endif
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef FCS_EN
            FCS: begin
                m_data_c  = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                m_valid_c = 1'b1;
                m_last_c  = (cnt_q[1:0] == 2'd3);
                if (m_ready) begin
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = IFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            IFG: begin
                if (cnt_q == CNT_W'(IFG_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef FCS_EN
        if (crc_en) crc_d = crc_next;
`endif
        stage_oh_d = stage_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            stage_oh_q <= STAGE_IDLE;
`ifdef FCS_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            stage_oh_q <= stage_oh_d;
`ifdef FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

    // Gated by rst so outputs are quiet for the whole reset cycle, not just after the edge.
    assign m_data       = m_data_c;
    assign m_valid      = rst & m_valid_c;
    assign m_last       = rst & m_last_c;
    assign s_ready      = rst & s_ready_c;
    assign err_oversize = rst & err_c;
    assign busy         = rst & (state_q != IDLE);
    assign stage_oh     = rst ? stage_oh_q : STAGE_IDLE;

endmodule

// File: tb/tb_eth_tx_stage_seq.sv
// Directed self-checking bench for eth_tx_stage_seq; expected streams come from
// a small frame model, including FCS when FCS_EN is defined.
module tb_eth_tx_stage_seq;

    localparam int PRE_LEN = 7;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;
    localparam int IFG_LEN = 12;
    localparam int BUDGET  = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic [3:0] stage_oh;
    logic       busy;
    logic       err_oversize;

    always #5 clk = ~clk;

    eth_tx_stage_seq #(
        .PRE_LEN (PRE_LEN),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .IFG_LEN (IFG_LEN),
        .CNT_W   (11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .stage_oh     (stage_oh),
        .busy         (busy),
        .err_oversize (err_oversize)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  pay[$];
    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    int          ifg_seen;
    int          err_seen;
    int          err_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-32: fold the byte into the low bits, then eight reflected shifts.
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic build_exp();
        int          n;
        int          fw;
        int          tot;
        bit          fcs;
        logic [31:0] c;
        logic [31:0] f;
        logic [7:0]  b;
        n   = pay.size();
        fw  = (n > MAX_LEN) ? MAX_LEN : n;
        tot = (fw < MIN_LEN) ? MIN_LEN : fw;
        fcs = 1'b0;
`ifdef FCS_EN
        fcs = 1'b1;
`endif
        c = 32'hFFFF_FFFF;
        exp_q.delete();
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({4'b0001, 1'b0, 8'h55});
        exp_q.push_back({4'b0001, 1'b0, 8'hD5});
        for (int i = 0; i < tot; i++) begin
            b = (i < fw) ? pay[i] : 8'h00;
            c = crc_ref(c, b);
            exp_q.push_back({(i < fw) ? 4'b0010 : 4'b0100,
                             (!fcs && i == tot - 1 && n <= MAX_LEN), b});
        end
        if (fcs) begin
            f = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back({4'b1000, (k == 3), f[8*k +: 8]});
        end
    endtask

    task automatic run_frame(input bit stall, input int abort_at);
        int         idx;
        int         cyc;
        bit         hold;
        bit         done;
        logic [7:0] hold_d;
        idx      = 0;
        cyc      = 0;
        hold     = 1'b0;
        hold_d   = '0;
        done     = 1'b0;
        ifg_seen = 0;
        err_seen = 0;
        err_idx  = -1;
        got_q.delete();
        while (!done) begin
            s_valid = (idx < pay.size());
            s_data  = s_valid ? pay[idx] : 8'h00;
            s_last  = s_valid && (idx == pay.size() - 1);
            m_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (hold) begin
                check_eq("hold_valid", 32'(m_valid), 32'd1);
                check_eq("hold_data", 32'(m_data), 32'(hold_d));
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            if (stall && !m_ready) check_eq("s_ready_in_stall", 32'(s_ready), 32'd0);
            if (m_valid && m_ready) got_q.push_back({stage_oh, m_last, m_data});
            if (busy && !m_valid && stage_oh == 4'b0000) ifg_seen++;
            if (err_oversize) begin
                err_seen++;
                err_idx = idx;
            end
            if (s_valid && s_ready) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                done = 1'b1;
            end else if (idx == pay.size() && !busy) begin
                done = 1'b1;
            end else if (cyc > BUDGET) begin
                check_eq("frame_timeout", 32'(cyc), 32'(BUDGET));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic compare_frame(input string name);
        int n;
        build_exp();
        check_eq({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check_eq({name, "_ifg"}, 32'(ifg_seen), 32'(IFG_LEN));
        check_eq({name, "_err_cnt"}, 32'(err_seen), (pay.size() > MAX_LEN) ? 32'd1 : 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, 32'({m_valid, m_last, s_ready, stage_oh, busy, err_oversize}), 32'd0);
    endtask

    initial begin
        int lasts;

        // Reset holds outputs quiet even with a client request pending.
        rst     = 1'b0;
        s_valid = 1'b1;
        s_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;

        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'(i));
        run_frame(1'b0, -1);
        compare_frame("pay64");

        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'(8'hA0 + i));
        run_frame(1'b0, -1);
        compare_frame("pay10_pad");

        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        run_frame(1'b0, -1);
        compare_frame("ascii9");

        pay.delete();
        for (int i = 0; i < 70; i++) pay.push_back(8'($urandom_range(0, 255)));
        run_frame(1'b1, -1);
        compare_frame("stall70");

        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'(8'hC3 ^ i));
        run_frame(1'b1, -1);
        compare_frame("stall20_pad");

        pay.delete();
        for (int i = 0; i < 1520; i++) pay.push_back(8'(i) ^ 8'h5A);
        run_frame(1'b0, -1);
        compare_frame("oversize");
        check_eq("oversize_err_at", 32'(err_idx), 32'(MAX_LEN));

        pay.delete();
        for (int i = 0; i < 40; i++) pay.push_back(8'(8'h11 * i));
        run_frame(1'b0, 20);
        lasts = 0;
        foreach (got_q[i]) if (got_q[i][8]) lasts++;
        check_eq("abort_no_last", 32'(lasts), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_rst_now");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort_rst_next");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'(8'hE0 + i));
        run_frame(1'b0, -1);
        compare_frame("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
